// File: rtl/mem_stage.sv
// mem_stage: serialises up to two loads/stores per bundle onto one data-bus port and builds the writeback bundle.
// Optional MEM_MISALIGN_EXC_EN: misaligned half/word lanes skip the bus and raise wb_exc instead.
module mem_stage #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [1:0]          ex_lane_valid,
  input  logic [1:0]          ex_is_load,
  input  logic [1:0]          ex_is_store,
  input  logic [3:0]          ex_size,
  input  logic [1:0]          ex_sign,
  input  logic [2*ADDR_W-1:0] ex_addr,
  input  logic [63:0]         ex_wdata,
  input  logic [63:0]         ex_result,
  input  logic [9:0]          ex_wreg,
  output logic                dm_req,
  output logic                dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [3:0]          dm_be,
  output logic [31:0]         dm_wdata,
  input  logic                dm_gnt,
  input  logic                dm_rvalid,
  input  logic [31:0]         dm_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [1:0]          wb_we,
  output logic [9:0]          wb_wreg,
  output logic [63:0]         wb_data,
`ifdef MEM_MISALIGN_EXC_EN
  output logic [1:0]          wb_exc,
`endif
  output logic                bus_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_reg, state_next;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_of(input logic [1:0] size, input logic sign,
                                          input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   v = {{24{sign & b[7]}}, b};
      2'b01:   v = {{16{sign & h[15]}}, h};
      default: v = rd;
    endcase
    return v;
  endfunction

`ifdef MEM_MISALIGN_EXC_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b01) ? off[0] : ((size != 2'b00) && (off != 2'b00));
  endfunction
`endif

  // Per-lane classification of the incoming bundle
  logic [1:0] lane_mem;
  logic [1:0] lane_exc;
  logic [1:0] lane_we;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
`ifdef MEM_MISALIGN_EXC_EN
    assign lane_exc[gi] = ex_lane_valid[gi] & (ex_is_load[gi] | ex_is_store[gi]) &
                          misaligned(ex_size[2*gi +: 2], ex_addr[gi*ADDR_W +: 2]);
`else
    assign lane_exc[gi] = 1'b0;
`endif
    assign lane_mem[gi] = ex_lane_valid[gi] & (ex_is_load[gi] | ex_is_store[gi]) & ~lane_exc[gi];
    assign lane_we[gi]  = ex_lane_valid[gi] & ~ex_is_store[gi] &
                          (ex_wreg[5*gi +: 5] != 5'd0) & ~lane_exc[gi];
  end

  // First request comes straight from the execute bundle; lane 0 wins when both are memory ops
  logic              first_lane;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_store;

  assign first_lane = ~lane_mem[0];
  assign sel_size   = ex_size[2*first_lane +: 2];
  assign sel_addr   = ex_addr[ADDR_W*first_lane +: ADDR_W];
  assign sel_wdata  = ex_wdata[32*first_lane +: 32];
  assign sel_store  = ex_is_store[first_lane];

  // Latched bundle state
  logic              lane_reg;
  logic              pend1_reg;
  logic [1:0]        lat_load_reg;
  logic              lat_store1_reg;
  logic [3:0]        lat_size_reg;
  logic [1:0]        lat_sign_reg;
  logic [3:0]        lat_off_reg;
  logic [ADDR_W-3:0] lat_addr1_reg;
  logic [31:0]       lat_wdata1_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;

  logic              dm_we_reg;
  logic [ADDR_W-1:0] dm_addr_reg;
  logic [3:0]        dm_be_reg;
  logic [31:0]       dm_wdata_reg;
  logic [1:0]        wb_we_reg;
  logic [9:0]        wb_wreg_reg;
  logic [63:0]       wb_data_reg;
  logic              bus_err_reg;
`ifdef MEM_MISALIGN_EXC_EN
  logic [1:0]        wb_exc_reg;
`endif

  logic capture;
  logic complete;
  logic timeout;
  logic more_lane;

  assign more_lane = (lane_reg == 1'b0) && pend1_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ex_valid) begin
          capture    = 1'b1;
          state_next = (|lane_mem) ? REQ : DONE;
        end
      end
      REQ: begin
        if (dm_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (dm_rvalid) begin
          complete = 1'b1;
        end else if ((MAX_WAIT != 0) && (wait_cnt_reg == WAIT_LAST)) begin
          complete = 1'b1;
          timeout  = 1'b1;
        end
        if (complete) state_next = more_lane ? REQ : DONE;
      end
      DONE: begin
        if (wb_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_reg       <= 1'b0;
      pend1_reg      <= 1'b0;
      lat_load_reg   <= '0;
      lat_store1_reg <= 1'b0;
      lat_size_reg   <= '0;
      lat_sign_reg   <= '0;
      lat_off_reg    <= '0;
      lat_addr1_reg  <= '0;
      lat_wdata1_reg <= '0;
      wait_cnt_reg   <= '0;
      dm_we_reg      <= 1'b0;
      dm_addr_reg    <= '0;
      dm_be_reg      <= '0;
      dm_wdata_reg   <= '0;
      wb_we_reg      <= '0;
      wb_wreg_reg    <= '0;
      wb_data_reg    <= '0;
      bus_err_reg    <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      wb_exc_reg     <= '0;
`endif
    end else begin
      if (capture) begin
        lane_reg       <= first_lane;
        pend1_reg      <= lane_mem[1];
        lat_load_reg   <= ex_is_load;
        lat_store1_reg <= ex_is_store[1];
        lat_size_reg   <= ex_size;
        lat_sign_reg   <= ex_sign;
        lat_off_reg    <= {ex_addr[ADDR_W +: 2], ex_addr[1:0]};
        lat_addr1_reg  <= ex_addr[2*ADDR_W-1:ADDR_W+2];
        lat_wdata1_reg <= ex_wdata[63:32];
        wb_we_reg      <= lane_we;
        wb_wreg_reg    <= ex_wreg;
        wb_data_reg    <= ex_result;
`ifdef MEM_MISALIGN_EXC_EN
        wb_exc_reg     <= lane_exc;
`endif
        if (|lane_mem) begin
          dm_we_reg    <= sel_store;
          dm_addr_reg  <= {sel_addr[ADDR_W-1:2], 2'b00};
          dm_be_reg    <= be_of(sel_size, sel_addr[1:0]);
          dm_wdata_reg <= wdata_of(sel_size, sel_wdata);
        end
      end

      // Watchdog: restarts at grant, stops at its last value
      if (state_reg == REQ && dm_gnt)
        wait_cnt_reg <= '0;
      else if (state_reg == WAIT && MAX_WAIT != 0 && wait_cnt_reg != WAIT_LAST)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;

      if (complete) begin
        if (timeout) begin
          wb_data_reg[32*lane_reg +: 32] <= '0;
          bus_err_reg                    <= 1'b1;
        end else if (lat_load_reg[lane_reg]) begin
          wb_data_reg[32*lane_reg +: 32] <= load_of(lat_size_reg[2*lane_reg +: 2], lat_sign_reg[lane_reg],
                                                    lat_off_reg[2*lane_reg +: 2], dm_rdata);
        end
        if (more_lane) begin
          lane_reg     <= 1'b1;
          dm_we_reg    <= lat_store1_reg;
          dm_addr_reg  <= {lat_addr1_reg, 2'b00};
          dm_be_reg    <= be_of(lat_size_reg[3:2], lat_off_reg[3:2]);
          dm_wdata_reg <= wdata_of(lat_size_reg[3:2], lat_wdata1_reg);
        end
      end
    end
  end

  assign ex_ready = (state_reg == IDLE);
  assign dm_req   = (state_reg == REQ);
  assign wb_valid = (state_reg == DONE);
  assign dm_we    = dm_we_reg;
  assign dm_addr  = dm_addr_reg;
  assign dm_be    = dm_be_reg;
  assign dm_wdata = dm_wdata_reg;
  assign wb_we    = wb_we_reg;
  assign wb_wreg  = wb_wreg_reg;
  assign wb_data  = wb_data_reg;
  assign bus_err  = bus_err_reg;
`ifdef MEM_MISALIGN_EXC_EN
  assign wb_exc   = wb_exc_reg;
`endif

endmodule
